amp_pwr_sequencer: RTL

//  Power-up/down sequencer for the amp frontend; sits directly upstream of timer_simple.

---
 rtl/amp_pwr_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/amp_pwr_sequencer.sv
// Power-up/down sequencer for the amp frontend. Times each phase through an external
// one-shot timer (start pulse out, idle-high timeout in) and gates bias/precharge/PWM/mute.
module amp_pwr_sequencer #(
  parameter int MAX_RETRY = 3,
  parameter int GUARD_CYC = 4
) (
  input  logic       clk_in,
  input  logic       resetb,
  input  logic       amp_enable,
  input  logic       fault_in,
  input  logic       fault_clear,
  input  logic       timer_timeout,
  output logic       timer_start,
  output logic       bias_en,
  output logic       precharge_en,
  output logic       pwm_en,
  output logic       mute_n,
  output logic       seq_ready,
  output logic       fault_lock,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_BIAS   = 3'd1,
    S_PRECHG = 3'd2,
    S_UNMUTE = 3'd3,
    S_RUN    = 3'd4,
    S_SHUTDN = 3'd5,
    S_FAULT  = 3'd6,
    S_LOCK   = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_started;
  logic        r_armed;
  logic [3:0]  r_guard;
  logic [2:0]  r_retry_cnt;
  logic        r_timer_start;
  logic [5:0]  r_outs;

  logic        w_timed;
  logic        w_fault_state;
  logic        w_done;
  logic        w_guard_exp;
  logic        w_active_fault;
  logic [2:0]  w_retry_inc;
  logic        w_rerun;
  logic        w_clr_retry;
  logic        w_new_phase;
  logic        w_fire;

  // Output vector order: {bias, precharge, pwm, mute_n, ready, lock}
  function automatic logic [5:0] f_decode(input state_t s);
    case (s)
      S_BIAS:   f_decode = 6'b100000;
      S_PRECHG: f_decode = 6'b110000;
      S_UNMUTE: f_decode = 6'b101000;
      S_RUN:    f_decode = 6'b101110;
      S_SHUTDN: f_decode = 6'b101000;
      S_LOCK:   f_decode = 6'b000001;
      default:  f_decode = 6'b000000;
    endcase
  endfunction

  assign w_timed = (r_state == S_BIAS) || (r_state == S_PRECHG) || (r_state == S_UNMUTE) ||
                   (r_state == S_SHUTDN) || (r_state == S_FAULT);
  assign w_fault_state = (r_state == S_BIAS) || (r_state == S_PRECHG) || (r_state == S_UNMUTE) ||
                         (r_state == S_RUN) || (r_state == S_SHUTDN);

  // A phase is only done once the timer was seen counting after our own pulse.
  assign w_done         = w_timed && r_armed && timer_timeout;
  assign w_guard_exp    = w_timed && r_started && !r_armed && timer_timeout &&
                          (r_guard >= 4'(GUARD_CYC));
  assign w_active_fault = fault_in && w_fault_state;
  assign w_retry_inc    = (r_retry_cnt == 3'd7) ? 3'd7 : r_retry_cnt + 3'd1;

  always_comb begin
    w_state_next = r_state;
    w_rerun      = 1'b0;
    w_clr_retry  = 1'b0;
    case (r_state)
      S_OFF: begin
        if (amp_enable && !fault_in) w_state_next = S_BIAS;
      end
      S_LOCK: begin
        if (fault_clear && !fault_in) begin
          w_state_next = S_OFF;
          w_clr_retry  = 1'b1;
        end
      end
      default: begin
        if (w_active_fault) begin
          w_state_next = (w_retry_inc == 3'(MAX_RETRY)) ? S_LOCK : S_FAULT;
        end else if (w_guard_exp) begin
          w_state_next = S_LOCK;
        end else begin
          case (r_state)
            S_BIAS: begin
              if (!amp_enable) w_state_next = S_OFF;
              else if (w_done) w_state_next = S_PRECHG;
            end
            S_PRECHG: begin
              if (!amp_enable) w_state_next = S_OFF;
              else if (w_done) w_state_next = S_UNMUTE;
            end
            S_UNMUTE: begin
              if (!amp_enable) w_state_next = S_SHUTDN;
              else if (w_done) w_state_next = S_RUN;
            end
            S_RUN: begin
              if (!amp_enable) w_state_next = S_SHUTDN;
            end
            S_SHUTDN: begin
              if (w_done) begin
                w_state_next = S_OFF;
                w_clr_retry  = 1'b1;
              end
            end
            S_FAULT: begin
              if (w_done) begin
                if (fault_in) w_rerun = 1'b1;
                else          w_state_next = S_OFF;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Handshake flags restart on every state entry and on a FAULT cooldown rerun.
  assign w_new_phase = (w_state_next != r_state) || w_rerun;
  assign w_fire      = w_timed && !r_started && timer_timeout && !w_new_phase;

  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      r_state       <= S_OFF;
      r_started     <= 1'b0;
      r_armed       <= 1'b0;
      r_guard       <= 4'd0;
      r_retry_cnt   <= 3'd0;
      r_timer_start <= 1'b0;
      r_outs        <= 6'b000000;
    end else begin
      r_state       <= w_state_next;
      r_timer_start <= w_fire;
      r_outs        <= f_decode(w_state_next);
      if (w_new_phase) begin
        r_started <= 1'b0;
        r_armed   <= 1'b0;
        r_guard   <= 4'd0;
      end else if (w_fire) begin
        r_started <= 1'b1;
        r_guard   <= 4'd0;
      end else if (r_started && !r_armed) begin
        if (!timer_timeout)       r_armed <= 1'b1;
        else if (r_guard != 4'hF) r_guard <= r_guard + 4'd1;
      end
      if (w_active_fault)
        r_retry_cnt <= w_retry_inc;
      else if (w_clr_retry || (fault_clear && r_state != S_LOCK))
        r_retry_cnt <= 3'd0;
    end
  end

  assign seq_state    = r_state;
  assign timer_start  = r_timer_start;
  assign bias_en      = r_outs[5];
  assign precharge_en = r_outs[4];
  assign pwm_en       = r_outs[3];
  assign mute_n       = r_outs[2];
  assign seq_ready    = r_outs[1];
  assign fault_lock   = r_outs[0];

endmodule
